// File: rtl/regfile_pkg.sv
// Shared constants, types and helpers for the multi-port register file.
package regfile_pkg;

   localparam int DEF_XLEN  = 32;
   localparam int DEF_NREGS = 32;

   typedef enum logic [1:0] {
      DUMP_IDLE = 2'd0,
      DUMP_RUN  = 2'd1,
      DUMP_DONE = 2'd2
   } dump_state_t;

   // Register index width for a file of n registers.
   function automatic int reg_aw(input int n);
      return $clog2(n);
   endfunction

endpackage

// File: rtl/regfile_if.sv
// Bus bundle of the register file: read ports, write ports and the dump stream.
interface regfile_if #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   parameter int NRD   = 2,
   parameter int NWR   = 1
);
   localparam int AW = $clog2(NREGS);

   logic [NRD*AW-1:0]   rs_num;
   logic [NRD*XLEN-1:0] rs_data;
   logic [NWR*AW-1:0]   rd_num;
   logic [NWR*XLEN-1:0] rd_data;
   logic [NWR-1:0]      rd_we;
   logic                halted;
   logic                dump_valid;
   logic                dump_ready;
   logic [AW-1:0]       dump_idx;
   logic [XLEN-1:0]     dump_data;
   logic                dump_done;

   // Core / testbench side.
   modport master (
      output rs_num, rd_num, rd_data, rd_we, halted, dump_ready,
      input  rs_data, dump_valid, dump_idx, dump_data, dump_done
   );

   // Register file side.
   modport slave (
      input  rs_num, rd_num, rd_data, rd_we, halted, dump_ready,
      output rs_data, dump_valid, dump_idx, dump_data, dump_done
   );
endinterface

// File: rtl/regfile_dump_fsm.sv
// Dump sequencer: detects the halt edge, walks indices 0..NREGS-1 under a
// valid/ready handshake and tells the top which register to load next.
module regfile_dump_fsm
   import regfile_pkg::*;
#(
   parameter int NREGS = DEF_NREGS,
   parameter int AW    = reg_aw(DEF_NREGS)
)(
   input  logic          clk,
   input  logic          rst_b,
   input  logic          halted,
   input  logic          dump_ready,
   output logic          dump_valid,
   output logic          dump_done,
   output logic [AW-1:0] dump_idx,
   output logic [AW-1:0] rd_idx_next,
   output logic          load_en
);

   localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

   dump_state_t   state_r;
   dump_state_t   state_nxt_s;
   logic          halted_q_r;
   logic          valid_r;
   logic          valid_nxt_s;
   logic          done_r;
   logic          done_nxt_s;
   logic [AW-1:0] idx_r;
   logic [AW-1:0] idx_nxt_s;
   logic          start_s;

   // A dump starts only on the rising edge of halted.
   assign start_s = halted & ~halted_q_r;

   // State, halt-edge history and registered dump outputs.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_r    <= DUMP_IDLE;
         halted_q_r <= 1'b0;
         valid_r    <= 1'b0;
         done_r     <= 1'b0;
         idx_r      <= '0;
      end else begin
         state_r    <= state_nxt_s;
         halted_q_r <= halted;
         valid_r    <= valid_nxt_s;
         done_r     <= done_nxt_s;
         idx_r      <= idx_nxt_s;
      end
   end

   // Next state and load requests; abort on halt release takes priority.
   always_comb begin
      state_nxt_s = state_r;
      valid_nxt_s = valid_r;
      done_nxt_s  = done_r;
      idx_nxt_s   = idx_r;
      rd_idx_next = idx_r;
      load_en     = 1'b0;
      case (state_r)
         DUMP_IDLE: begin
            if (start_s) begin
               state_nxt_s = DUMP_RUN;
               idx_nxt_s   = '0;
               valid_nxt_s = 1'b1;
               done_nxt_s  = 1'b0;
               rd_idx_next = '0;
               load_en     = 1'b1;
            end else begin
               valid_nxt_s = 1'b0;
               done_nxt_s  = 1'b0;
            end
         end
         DUMP_RUN: begin
            if (!halted) begin
               state_nxt_s = DUMP_IDLE;
               valid_nxt_s = 1'b0;
            end else if (valid_r && dump_ready) begin
               if (idx_r == LAST_IDX) begin
                  state_nxt_s = DUMP_DONE;
                  valid_nxt_s = 1'b0;
                  done_nxt_s  = 1'b1;
               end else begin
                  idx_nxt_s   = idx_r + AW'(1);
                  rd_idx_next = idx_r + AW'(1);
                  load_en     = 1'b1;
               end
            end else begin
               state_nxt_s = DUMP_RUN;
            end
         end
         DUMP_DONE: begin
            if (!halted) begin
               state_nxt_s = DUMP_IDLE;
               done_nxt_s  = 1'b0;
            end else begin
               done_nxt_s  = 1'b1;
            end
         end
         default: begin
            state_nxt_s = DUMP_IDLE;
            valid_nxt_s = 1'b0;
            done_nxt_s  = 1'b0;
         end
      endcase
   end

   assign dump_valid = valid_r;
   assign dump_done  = done_r;
   assign dump_idx   = idx_r;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with optional write-to-read bypass,
// hardwired x0 and a handshaked dump stream triggered by core halt.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int XLEN     = DEF_XLEN,
   parameter int NREGS    = DEF_NREGS,
   parameter int NRD      = 2,
   parameter int NWR      = 1,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 1
)(
   input logic       clk,
   input logic       rst_b,
   regfile_if.slave  bus
);

   localparam int AW = reg_aw(NREGS);

   logic [XLEN-1:0]     data_r [NREGS];
   logic [XLEN-1:0]     dump_data_r;
   logic [NRD*XLEN-1:0] rs_data_s;
   logic [AW-1:0]       rd_idx_next_s;
   logic                load_en_s;
   logic                dump_valid_s;
   logic                dump_done_s;
   logic [AW-1:0]       dump_idx_s;

   // Storage update; ascending port order lets the highest write port win.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         for (int r = 0; r < NREGS; r++) begin
            data_r[r] <= '0;
         end
      end else begin
         for (int k = 0; k < NWR; k++) begin
            if (bus.rd_we[k] &&
                !((ZERO_REG != 0) && (bus.rd_num[k*AW +: AW] == '0))) begin
               data_r[bus.rd_num[k*AW +: AW]] <= bus.rd_data[k*XLEN +: XLEN];
            end
         end
      end
   end

   // Combinational read ports: storage, then bypass (highest port last), then x0 override.
   always_comb begin
      logic [XLEN-1:0] val_v;
      logic [AW-1:0]   idx_v;
      logic            hit_v;
      rs_data_s = '0;
      val_v     = '0;
      idx_v     = '0;
      hit_v     = 1'b0;
      for (int i = 0; i < NRD; i++) begin
         idx_v = bus.rs_num[i*AW +: AW];
         val_v = data_r[idx_v];
         for (int k = 0; k < NWR; k++) begin
            hit_v = (BYPASS != 0) && bus.rd_we[k] && (bus.rd_num[k*AW +: AW] == idx_v);
            val_v = hit_v ? bus.rd_data[k*XLEN +: XLEN] : val_v;
         end
         val_v = ((ZERO_REG != 0) && (idx_v == '0)) ? '0 : val_v;
         rs_data_s[i*XLEN +: XLEN] = val_v;
      end
   end

   // Dump beat data, captured from pre-edge storage when a beat is loaded.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         dump_data_r <= '0;
      end else if (load_en_s) begin
         dump_data_r <= data_r[rd_idx_next_s];
      end
   end

   regfile_dump_fsm #(
      .NREGS (NREGS),
      .AW    (AW)
   ) u_fsm (
      .clk         (clk),
      .rst_b       (rst_b),
      .halted      (bus.halted),
      .dump_ready  (bus.dump_ready),
      .dump_valid  (dump_valid_s),
      .dump_done   (dump_done_s),
      .dump_idx    (dump_idx_s),
      .rd_idx_next (rd_idx_next_s),
      .load_en     (load_en_s)
   );

   assign bus.rs_data    = rs_data_s;
   assign bus.dump_valid = dump_valid_s;
   assign bus.dump_done  = dump_done_s;
   assign bus.dump_idx   = dump_idx_s;
   assign bus.dump_data  = dump_data_r;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: writes, bypass, x0, port priority and dump stream.
module tb_regfile_mp;
   import regfile_pkg::*;

   localparam int AW = 5;

   logic clk;
   logic rst_b;
   int   n_cmp;
   int   n_err;

   regfile_if #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2)) bus    ();
   regfile_if #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(1)) bus_nb ();

   regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(1), .ZERO_REG(1)) u_dut (
      .clk   (clk),
      .rst_b (rst_b),
      .bus   (bus)
   );

   regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(1), .BYPASS(0), .ZERO_REG(1)) u_dut_nb (
      .clk   (clk),
      .rst_b (rst_b),
      .bus   (bus_nb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_beat(input string tag, input logic v, input int idx, input logic [31:0] d);
      check_val({tag, "_valid"}, 32'(bus.dump_valid), 32'(v));
      check_val({tag, "_idx"},   32'(bus.dump_idx),   32'(idx));
      check_val({tag, "_data"},  bus.dump_data,       d);
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst_b = 1'b0;
      bus.rs_num = '0; bus.rd_num = '0; bus.rd_data = '0; bus.rd_we = '0;
      bus.halted = 1'b0; bus.dump_ready = 1'b0;
      bus_nb.rs_num = '0; bus_nb.rd_num = '0; bus_nb.rd_data = '0; bus_nb.rd_we = '0;
      bus_nb.halted = 1'b0; bus_nb.dump_ready = 1'b0;

      // Reset state
      #12;
      check_beat("rst", 1'b0, 0, 32'h0);
      check_val("rst_done", 32'(bus.dump_done), 32'h0);
      check_val("rst_rd0", bus.rs_data[31:0], 32'h0);
      rst_b = 1'b1;

      // Write x5 then read it back
      bus.rd_we = 2'b01; bus.rd_num[0 +: AW] = 5'd5; bus.rd_data[0 +: 32] = 32'hDEADBEEF;
      tick();
      bus.rd_we = 2'b00; bus.rs_num[0 +: AW] = 5'd5;
      #1;
      check_val("rd_x5", bus.rs_data[31:0], 32'hDEADBEEF);

      // x0: write dropped, same-cycle bypass also suppressed
      bus.rd_we = 2'b01; bus.rd_num[0 +: AW] = 5'd0; bus.rd_data[0 +: 32] = 32'h00001234;
      bus.rs_num[0 +: AW] = 5'd0;
      #1;
      check_val("x0_bypass", bus.rs_data[31:0], 32'h0);
      tick();
      bus.rd_we = 2'b00;
      #1;
      check_val("x0_store", bus.rs_data[31:0], 32'h0);

      // Same-cycle bypass on read port 1; the non-bypass instance shows the old value
      bus.rd_we = 2'b01; bus.rd_num[0 +: AW] = 5'd7; bus.rd_data[0 +: 32] = 32'hA5A5A5A5;
      bus.rs_num[AW +: AW] = 5'd7;
      bus_nb.rd_we = 1'b1; bus_nb.rd_num = 5'd7; bus_nb.rd_data = 32'hA5A5A5A5;
      bus_nb.rs_num[AW +: AW] = 5'd7;
      #1;
      check_val("byp_x7", bus.rs_data[63:32], 32'hA5A5A5A5);
      check_val("nobyp_x7", bus_nb.rs_data[63:32], 32'h0);
      tick();
      bus.rd_we = 2'b00; bus_nb.rd_we = 1'b0;
      #1;
      check_val("nobyp_x7_later", bus_nb.rs_data[63:32], 32'hA5A5A5A5);
      check_val("nobyp_idle", 32'(bus_nb.dump_valid), 32'h0);

      // Both write ports hit x3: port 1 wins, for bypass and storage
      bus.rd_we = 2'b11;
      bus.rd_num[0 +: AW] = 5'd3; bus.rd_data[0 +: 32] = 32'h00000011;
      bus.rd_num[AW +: AW] = 5'd3; bus.rd_data[32 +: 32] = 32'h00000022;
      bus.rs_num[0 +: AW] = 5'd3;
      #1;
      check_val("prio_byp_x3", bus.rs_data[31:0], 32'h00000022);
      tick();
      bus.rd_we = 2'b00;
      #1;
      check_val("prio_x3", bus.rs_data[31:0], 32'h00000022);

      // Two distinct writes bypassed to two read ports
      bus.rd_we = 2'b11;
      bus.rd_num[0 +: AW] = 5'd4; bus.rd_data[0 +: 32] = 32'h00000044;
      bus.rd_num[AW +: AW] = 5'd6; bus.rd_data[32 +: 32] = 32'h00000066;
      bus.rs_num[0 +: AW] = 5'd4; bus.rs_num[AW +: AW] = 5'd6;
      #1;
      check_val("byp_p0_x4", bus.rs_data[31:0], 32'h00000044);
      check_val("byp_p1_x6", bus.rs_data[63:32], 32'h00000066);
      tick();
      bus.rd_we = 2'b00;

      // Preload x1..x31 = 3*i
      for (int i = 1; i < 32; i++) begin
         bus.rd_we = 2'b01; bus.rd_num[0 +: AW] = 5'(i); bus.rd_data[0 +: 32] = 32'(i * 3);
         tick();
      end
      bus.rd_we = 2'b00;

      // Full dump with ready held high
      bus.halted = 1'b1; bus.dump_ready = 1'b1;
      tick();
      for (int b = 0; b < 32; b++) begin
         check_beat($sformatf("dump%0d", b), 1'b1, b, 32'(b * 3));
         tick();
      end
      check_val("dump_end_valid", 32'(bus.dump_valid), 32'h0);
      check_val("dump_end_done", 32'(bus.dump_done), 32'h1);
      bus.halted = 1'b0;
      tick();
      check_val("done_clear", 32'(bus.dump_done), 32'h0);
      check_val("done_idle", 32'(u_dut.u_fsm.state_r), 32'(DUMP_IDLE));

      // Second dump: stall at idx 10 with a write to x10 during the stall
      bus.halted = 1'b1;
      tick();
      for (int b = 0; b < 10; b++) tick();
      check_beat("pre_stall", 1'b1, 10, 32'd30);
      bus.dump_ready = 1'b0;
      bus.rd_we = 2'b01; bus.rd_num[0 +: AW] = 5'd10; bus.rd_data[0 +: 32] = 32'h000000FF;
      for (int s = 0; s < 4; s++) begin
         tick();
         bus.rd_we = 2'b00;
         check_beat($sformatf("stall%0d", s), 1'b1, 10, 32'd30);
      end
      bus.rs_num[0 +: AW] = 5'd10;
      #1;
      check_val("x10_after_stall", bus.rs_data[31:0], 32'h000000FF);
      bus.dump_ready = 1'b1;
      tick();
      check_beat("resume11", 1'b1, 11, 32'd33);
      tick();
      check_beat("resume12", 1'b1, 12, 32'd36);

      // Abort at idx 12
      bus.halted = 1'b0;
      tick();
      check_val("abort_valid", 32'(bus.dump_valid), 32'h0);
      check_val("abort_idle", 32'(u_dut.u_fsm.state_r), 32'(DUMP_IDLE));

      // Re-halt restarts at 0
      bus.halted = 1'b1; bus.dump_ready = 1'b0;
      tick();
      check_beat("rehalt0", 1'b1, 0, 32'h0);
      bus.dump_ready = 1'b1;
      tick();
      check_beat("rehalt1", 1'b1, 1, 32'd3);
      tick();
      check_beat("rehalt2", 1'b1, 2, 32'd6);

      // Asynchronous reset mid-dump
      bus.rs_num[0 +: AW] = 5'd5;
      #2;
      rst_b = 1'b0;
      #1;
      check_beat("arst", 1'b0, 0, 32'h0);
      check_val("arst_done", 32'(bus.dump_done), 32'h0);
      check_val("arst_x5", bus.rs_data[31:0], 32'h0);
      check_val("arst_idle", 32'(u_dut.u_fsm.state_r), 32'(DUMP_IDLE));
      bus.halted = 1'b0;
      #3;
      rst_b = 1'b1;
      tick();
      check_val("post_rst_valid", 32'(bus.dump_valid), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
